jk_master_slave_reg: RTL and testbench

Master-slave JK storage register. Each bit is a JK flip-flop split into a master stage and a slave stage. The master captures the next state on the rising edge of `clk`; the slave publishes it on the following falling edge. It is a generic sequential primitive used wherever JK hold/reset/set/toggle semantics are needed, and WIDTH independent bits share one clock and reset.

---
 rtl/jk_master_slave_reg_pkg.sv | 24 ++
 rtl/jk_ms_cell.sv | 44 ++++
 rtl/jk_master_slave_reg.sv | 30 +++
 tb/tb_jk_master_slave_reg.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/jk_master_slave_reg_pkg.sv
// JK operation encoding and the per-bit next-state function shared by the
// master/slave cells.
package jk_master_slave_reg_pkg;

  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_op_e;

  function automatic logic jk_next(input logic j, input logic k, input logic q);
    logic nxt;
    case (jk_op_e'({j, k}))
      JK_HOLD:   nxt = q;
      JK_RESET:  nxt = 1'b0;
      JK_SET:    nxt = 1'b1;
      JK_TOGGLE: nxt = ~q;
      default:   nxt = q;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jk_ms_cell.sv
// Single JK bit: master flop on the rising edge, slave flop on the falling edge,
// both cleared asynchronously by rst_n.
module jk_ms_cell
  import jk_master_slave_reg_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic m_q,
  output logic q
);

  logic master_d;
  logic master_q;
  logic slave_q;

  // Next master value is always computed from the stable slave output.
  always_comb begin
    master_d = jk_next(j, k, slave_q);
  end

  // Master stage captures on the rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      master_q <= 1'b0;
    end else begin
      master_q <= master_d;
    end
  end

  // Slave stage publishes the master value on the falling edge.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slave_q <= 1'b0;
    end else begin
      slave_q <= master_q;
    end
  end

  assign m_q = master_q;
  assign q   = slave_q;

endmodule

// File: rtl/jk_master_slave_reg.sv
// WIDTH independent master-slave JK flip-flops sharing one clock and reset;
// q_n is the plain complement of the slave state.
module jk_master_slave_reg
  import jk_master_slave_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic [WIDTH-1:0] m_q
);

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
    jk_ms_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .j     (j[i]),
      .k     (k[i]),
      .m_q   (m_q[i]),
      .q     (q[i])
    );
  end

  assign q_n = ~q;

endmodule

// File: tb/tb_jk_master_slave_reg.sv
// Self-checking bench for jk_master_slave_reg (WIDTH=4): reset, table-driven JK
// sequences with a scoreboard queue, half-cycle input change and mid-cycle reset.
module tb_jk_master_slave_reg;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] j;
  logic [W-1:0] k;
  logic [W-1:0] q;
  logic [W-1:0] q_n;
  logic [W-1:0] m_q;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [W-1:0] j;
    logic [W-1:0] k;
    logic [W-1:0] exp_q;
  } vec_t;

  vec_t         vecs[$];
  logic [W-1:0] exp_queue[$];
  logic [W-1:0] cur_q;

  jk_master_slave_reg #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .j     (j),
    .k     (k),
    .q     (q),
    .q_n   (q_n),
    .m_q   (m_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%b required=%b at t=%0t", name, act, req, $time);
    end
  endtask

  // Called with clk low just after a falling edge: drive, push, then compare.
  task automatic step(input logic [W-1:0] jv, input logic [W-1:0] kv, input logic [W-1:0] exp);
    logic [W-1:0] got_exp;
    j = jv;
    k = kv;
    exp_queue.push_back(exp);
    @(posedge clk); #1;
    check("m_q_after_rise", m_q, exp);
    check("q_held_while_high", q, cur_q);
    @(negedge clk); #1;
    if (exp_queue.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty: actual=empty required=entry");
    end else begin
      got_exp = exp_queue.pop_front();
      check("q_after_fall", q, got_exp);
      check("q_n_after_fall", q_n, ~got_exp);
      cur_q = got_exp;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Vectors applied from the state q = 4'b1111 left by the reset test.
    vecs.push_back('{j: 4'b0000, k: 4'b1111, exp_q: 4'b0000});
    vecs.push_back('{j: 4'b1111, k: 4'b0000, exp_q: 4'b1111});
    vecs.push_back('{j: 4'b0000, k: 4'b0000, exp_q: 4'b1111});
    vecs.push_back('{j: 4'b0000, k: 4'b0000, exp_q: 4'b1111});
    vecs.push_back('{j: 4'b0000, k: 4'b0000, exp_q: 4'b1111});
    vecs.push_back('{j: 4'b0000, k: 4'b1111, exp_q: 4'b0000});
    vecs.push_back('{j: 4'b1111, k: 4'b1111, exp_q: 4'b1111});
    vecs.push_back('{j: 4'b1111, k: 4'b1111, exp_q: 4'b0000});
    vecs.push_back('{j: 4'b1111, k: 4'b1111, exp_q: 4'b1111});
    vecs.push_back('{j: 4'b1111, k: 4'b1111, exp_q: 4'b0000});
    vecs.push_back('{j: 4'b1111, k: 4'b1111, exp_q: 4'b1111});
    vecs.push_back('{j: 4'b1111, k: 4'b1111, exp_q: 4'b0000});

    // Reset held with 11 on the inputs and the clock running.
    rst_n = 1'b0;
    j     = 4'b1111;
    k     = 4'b1111;
    cur_q = 4'b0000;
    #1;
    check("rst_q", q, 4'b0000);
    check("rst_q_n", q_n, 4'b1111);
    check("rst_m_q", m_q, 4'b0000);
    @(posedge clk); #1;
    check("rst_m_q_after_rise", m_q, 4'b0000);
    @(negedge clk); #1;
    check("rst_q_after_fall", q, 4'b0000);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("release_m_q", m_q, 4'b1111);
    check("release_q_still_low", q, 4'b0000);
    @(negedge clk); #1;
    check("release_q", q, 4'b1111);
    cur_q = 4'b1111;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].j, vecs[i].k, vecs[i].exp_q);
    end

    // Inputs change from 10 to 01 while clk is high: the sampled 10 wins.
    j = 4'b1111;
    k = 4'b0000;
    @(posedge clk); #1;
    check("half_m_q", m_q, 4'b1111);
    j = 4'b0000;
    k = 4'b1111;
    @(negedge clk); #1;
    check("half_q_set", q, 4'b1111);
    cur_q = 4'b1111;
    step(4'b0000, 4'b1111, 4'b0000);

    // Per-bit independence: reach 0101, then toggle/set/reset/hold per bit.
    step(4'b0101, 4'b1010, 4'b0101);
    step(4'b1100, 4'b1010, 4'b1101);

    // Reset asserted between rising and falling edge with 11 pending.
    j = 4'b1111;
    k = 4'b1111;
    @(posedge clk); #1;
    check("mid_m_q_pending", m_q, 4'b0010);
    #1 rst_n = 1'b0;
    #1;
    check("mid_q_cleared", q, 4'b0000);
    check("mid_m_q_cleared", m_q, 4'b0000);
    check("mid_q_n", q_n, 4'b1111);
    @(negedge clk); #1;
    check("mid_no_fall_update", q, 4'b0000);
    #2 rst_n = 1'b1;
    cur_q = 4'b0000;
    step(4'b1010, 4'b0101, 4'b1010);

    n_checks++;
    if (exp_queue.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: actual=%0d required=0", exp_queue.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
